// File: rtl/frame_loader_pkg.sv
// Shared types and sizing helpers for the frame loader.
package frame_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fl_state_t;

    localparam int FL_DATA_W_DEFAULT = 10;
    localparam int FL_LOG2_N_DEFAULT = 10;

    function automatic int flFrameLen(input int log2n);
        return 1 << log2n;
    endfunction

    function automatic int flAddrWidth(input int log2n);
        return log2n + 1;
    endfunction

endpackage

// File: rtl/frame_loader_if.sv
// Sample stream, control and RAM-write signals of the frame loader.
interface frame_loader_if
    import frame_loader_pkg::*;
#(
    parameter int DATA_W = FL_DATA_W_DEFAULT,
    parameter int LOG2_N = FL_LOG2_N_DEFAULT
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              start;
    logic              cont;
    logic              abort;
    logic              busy;
    logic              frame_done;
    logic              bank;
    logic              mem_we;
    logic [LOG2_N:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Master is the sample source plus FFT controller; slave is the loader.
    modport master (
        output s_valid, s_data, start, cont, abort,
        input  s_ready, busy, frame_done, bank, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  s_valid, s_data, start, cont, abort,
        output s_ready, busy, frame_done, bank, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/frame_loader_bit_reverse.sv
// Combinational WIDTH-bit bit reversal used for in-place FFT addressing.
module bit_reverse #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    always_comb begin
        o_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_data[i] = i_data[WIDTH-1-i];
        end
    end
endmodule

// File: rtl/frame_loader.sv
// Ping-pong frame loader: writes one frame of 2**LOG2_N samples into FFT RAM.
// Define FRAME_LOADER_BITREV_EN to write samples at bit-reversed indices.
module frame_loader
    import frame_loader_pkg::*;
#(
    parameter int DATA_W = FL_DATA_W_DEFAULT,
    parameter int LOG2_N = FL_LOG2_N_DEFAULT
) (
    input logic           clk,
    input logic           rst_n,
    frame_loader_if.slave bus
);
    localparam int N      = flFrameLen(LOG2_N);
    localparam int ADDR_W = flAddrWidth(LOG2_N);
    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N - 1);

    fl_state_t         r_state;
    logic [LOG2_N-1:0] r_idx;
    logic              r_wrBank;
    logic              r_bank;
    logic              r_frameDone;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;

    logic              w_sReady;
    logic              w_accept;
    logic [LOG2_N-1:0] w_mapIdx;

`ifdef FRAME_LOADER_BITREV_EN
    bit_reverse #(.WIDTH(LOG2_N)) u_bitReverse (
        .i_data (r_idx),
        .o_data (w_mapIdx)
    );
`else
    assign w_mapIdx = r_idx;
`endif

    assign w_sReady = (r_state == FILL);
    assign w_accept = bus.s_valid & w_sReady;

    // A beat accepted alongside abort is still written; only the frame is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_wrBank    <= 1'b0;
            r_bank      <= 1'b0;
            r_frameDone <= 1'b0;
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
        end else begin
            r_memWe     <= w_accept;
            r_frameDone <= 1'b0;
            if (w_accept) begin
                r_memAddr  <= {r_wrBank, w_mapIdx};
                r_memWdata <= bus.s_data;
                r_idx      <= r_idx + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= FILL;
                        r_idx   <= '0;
                    end
                end
                FILL: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                    end else if (w_accept && (r_idx == LAST_IDX)) begin
                        r_state     <= DONE;
                        r_frameDone <= 1'b1;
                        r_bank      <= r_wrBank;
                        r_wrBank    <= ~r_wrBank;
                    end
                end
                DONE: begin
                    if (bus.abort || !bus.cont) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= FILL;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready    = w_sReady;
    assign bus.busy       = (r_state != IDLE);
    assign bus.frame_done = r_frameDone;
    assign bus.bank       = r_bank;
    assign bus.mem_we     = r_memWe;
    assign bus.mem_addr   = r_memAddr;
    assign bus.mem_wdata  = r_memWdata;
endmodule
